// File: rtl/ysyx_25040111_rd_arb_if.sv
// Requester-side (icache/LSU) and memory-side AXI read signals of the read arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface ysyx_25040111_rd_arb_if;
  logic        ic_arvalid, ic_arready;
  logic [31:0] ic_araddr;
  logic [7:0]  ic_arlen;
  logic        ic_rvalid, ic_rlast;
  logic [31:0] ic_rdata;
  logic        ls_arvalid, ls_arready;
  logic [31:0] ls_araddr;
  logic [2:0]  ls_arsize;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        rd_err, rd_err_own;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready, m_rlast;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  modport slave (
    input  ic_arvalid, ic_araddr, ic_arlen, ls_arvalid, ls_araddr, ls_arsize,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output ic_arready, ic_rvalid, ic_rdata, ic_rlast, ls_arready, ls_rvalid, ls_rdata,
           rd_err, rd_err_own, m_arvalid, m_araddr, m_arid, m_arlen, m_arsize,
           m_arburst, m_rready
  );

  modport master (
    output ic_arvalid, ic_araddr, ic_arlen, ls_arvalid, ls_araddr, ls_arsize,
           m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  ic_arready, ic_rvalid, ic_rdata, ic_rlast, ls_arready, ls_rvalid, ls_rdata,
           rd_err, rd_err_own, m_arvalid, m_araddr, m_arid, m_arlen, m_arsize,
           m_arburst, m_rready
  );
endinterface

// File: rtl/ysyx_25040111_rd_arb.sv
// Round-robin read arbiter: icache bursts and LSU single loads share one AXI4 read
// port, one transaction in flight, R beats routed back to the owner with error flagging.
module ysyx_25040111_rd_arb #(
  parameter logic [3:0] IC_ID = 4'd0,
  parameter logic [3:0] LS_ID = 4'd1
) (
  input  logic clock,
  input  logic reset,
  ysyx_25040111_rd_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 1: LSU owned the last grant
  logic        own_q, own_d;             // 0 icache, 1 LSU
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_own_q, err_own_d;
  logic        ic_arready_q, ic_arready_d;
  logic        ls_arready_q, ls_arready_d;

  logic beat, at_len, err, pick_ls;

  assign beat   = (state_q == DATA) && bus.m_rvalid;
  assign at_len = (cnt_q == len_q);
  assign err    = beat && ((bus.m_rresp != 2'b00) || (bus.m_rlast != at_len));

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    own_d        = own_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    err_own_d    = err_own_q;
    ic_arready_d = 1'b0;
    ls_arready_d = 1'b0;
    pick_ls      = 1'b0;
    case (state_q)
      IDLE: if (bus.ic_arvalid || bus.ls_arvalid) begin
        // On a tie the side that did not win last time gets the port.
        pick_ls    = bus.ls_arvalid && (!bus.ic_arvalid || !last_gnt_q);
        own_d      = pick_ls;
        last_gnt_d = pick_ls;
        state_d    = ADDR;
        if (pick_ls) begin
          addr_d       = bus.ls_araddr;
          len_d        = 8'd0;
          size_d       = bus.ls_arsize;
          id_d         = LS_ID;
          ls_arready_d = 1'b1;
        end else begin
          addr_d       = bus.ic_araddr;
          len_d        = bus.ic_arlen;
          size_d       = 3'b010;
          id_d         = IC_ID;
          ic_arready_d = 1'b1;
        end
      end
      ADDR: if (bus.m_arready) begin
        state_d = DATA;
        cnt_d   = 8'd0;
      end
      DATA: if (beat) begin
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        // Only RLAST closes the transaction, even on a length mismatch.
        if (bus.m_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (err) err_own_d = own_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      own_q        <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      err_own_q    <= 1'b0;
      ic_arready_q <= 1'b0;
      ls_arready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      own_q        <= own_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      err_own_q    <= err_own_d;
      ic_arready_q <= ic_arready_d;
      ls_arready_q <= ls_arready_d;
    end
  end

  assign bus.ic_arready = ic_arready_q;
  assign bus.ls_arready = ls_arready_q;

  assign bus.m_arvalid  = (state_q == ADDR);
  assign bus.m_araddr   = addr_q;
  assign bus.m_arid     = id_q;
  assign bus.m_arlen    = len_q;
  assign bus.m_arsize   = size_q;
  assign bus.m_arburst  = (state_q == ADDR) ? 2'b01 : 2'b00;
  assign bus.m_rready   = (state_q == DATA);

  assign bus.ic_rvalid  = beat && !own_q;
  assign bus.ic_rdata   = bus.ic_rvalid ? bus.m_rdata : 32'd0;
  assign bus.ic_rlast   = bus.ic_rvalid && at_len;
  assign bus.ls_rvalid  = beat && own_q;
  assign bus.ls_rdata   = bus.ls_rvalid ? bus.m_rdata : 32'd0;

  assign bus.rd_err     = err;
  assign bus.rd_err_own = err ? own_q : err_own_q;
endmodule

// File: tb/tb_ysyx_25040111_rd_arb.sv
// Directed bench for the read arbiter: AR and R expectations are queued from a
// small behavioural model when stimulus is driven and checked as the DUT responds.
`define CHK(tag, o, e) chk(tag, 128'(o), 128'(e))

module tb_ysyx_25040111_rd_arb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_25040111_rd_arb_if bus();
  ysyx_25040111_rd_arb #(.IC_ID(4'd0), .LS_ID(4'd1)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] addr; logic [3:0] id; logic [7:0] len; logic [2:0] size; logic own;
  } ar_t;
  typedef struct packed {
    logic own; logic [31:0] data; logic last; logic err; logic err_own;
  } beat_t;

  ar_t   ar_q[$];
  beat_t bt_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  mdl_err_own = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [121:0] all_outs();
    return {bus.ic_arready, bus.ic_rvalid, bus.ic_rdata, bus.ic_rlast,
            bus.ls_arready, bus.ls_rvalid, bus.ls_rdata, bus.rd_err, bus.rd_err_own,
            bus.m_arvalid, bus.m_araddr, bus.m_arid, bus.m_arlen, bus.m_arsize,
            bus.m_arburst, bus.m_rready};
  endfunction

  task automatic push_ar(input logic own, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    ar_t a;
    a.own  = own;
    a.addr = addr;
    a.id   = own ? 4'd1 : 4'd0;
    a.len  = own ? 8'd0 : len;
    a.size = own ? size : 3'b010;
    ar_q.push_back(a);
  endtask

  // Wait for the AR phase, check it against the queue, accept it one cycle late.
  task automatic wait_ar(input bit drop_ic, input bit drop_ls);
    ar_t e;
    bit  seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.m_arvalid === 1'b1) seen = 1'b1;
    end
    tests++;
    assert (seen) else begin
      fails++;
      $error("FAIL ar_timeout observed=0 expected=1");
    end
    if (!seen || ar_q.size() == 0) return;
    e = ar_q.pop_front();
    `CHK("araddr", bus.m_araddr, e.addr);
    `CHK("arid", bus.m_arid, e.id);
    `CHK("arlen", bus.m_arlen, e.len);
    `CHK("arsize", bus.m_arsize, e.size);
    `CHK("arburst", bus.m_arburst, 2'b01);
    `CHK("arready_grant", {bus.ic_arready, bus.ls_arready}, (e.own ? 2'b01 : 2'b10));
    if (drop_ic) bus.ic_arvalid = 1'b0;
    if (drop_ls) bus.ls_arvalid = 1'b0;
    step();
    `CHK("ar_hold", {bus.m_arvalid, bus.m_araddr, bus.m_arid}, {1'b1, e.addr, e.id});
    `CHK("arready_pulse", {bus.ic_arready, bus.ls_arready}, 2'b00);
    bus.m_arready = 1'b1;
    step();
    bus.m_arready = 1'b0;
    `CHK("data_rready", {bus.m_rready, bus.m_arvalid}, 2'b10);
  endtask

  // Drive n beats; m_rlast on beat last_at; model expected routing/rlast/error.
  task automatic beats(input logic own, input int n, input int len,
                       input int last_at, input logic [1:0] resp);
    beat_t e, g;
    logic [31:0] d;
    logic lst;
    for (int i = 0; i < n; i++) begin
      d   = $urandom;
      lst = (i == last_at);
      e.own  = own;
      e.data = d;
      e.last = !own && (i == len);
      e.err  = (resp != 2'b00) || (lst != (i == len));
      if (e.err) mdl_err_own = own;
      e.err_own = mdl_err_own;
      bt_q.push_back(e);
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = d;
      bus.m_rlast  = lst;
      bus.m_rresp  = resp;
      #1;
      g = bt_q.pop_front();
      `CHK("ic_rvalid", bus.ic_rvalid, !g.own);
      `CHK("ls_rvalid", bus.ls_rvalid, g.own);
      `CHK("rdata", (g.own ? bus.ls_rdata : bus.ic_rdata), g.data);
      `CHK("ic_rlast", bus.ic_rlast, g.last);
      `CHK("rd_err", bus.rd_err, g.err);
      `CHK("rd_err_own", bus.rd_err_own, g.err_own);
      step();
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.m_rresp  = 2'b00;
    #1;
    `CHK("back_idle", {bus.m_rready, bus.m_arvalid, bus.rd_err}, 3'b000);
    `CHK("err_own_hold", bus.rd_err_own, mdl_err_own);
  endtask

  initial begin
    bus.ic_arvalid = 1'b0; bus.ic_araddr = '0; bus.ic_arlen = '0;
    bus.ls_arvalid = 1'b0; bus.ls_araddr = '0; bus.ls_arsize = '0;
    bus.m_arready  = 1'b0; bus.m_rvalid  = 1'b0; bus.m_rdata = '0;
    bus.m_rresp    = 2'b00; bus.m_rlast  = 1'b0;
    reset = 1'b1;
    step(); step();
    `CHK("reset_outs", all_outs(), 122'd0);
    reset = 1'b0;
    step();
    bus.m_rvalid = 1'b1;
    #1;
    `CHK("idle_rvalid_ignored", {bus.m_rready, bus.ic_rvalid, bus.ls_rvalid, bus.rd_err}, 4'd0);
    bus.m_rvalid = 1'b0;

    // Simultaneous requests after reset: icache first, then LSU.
    bus.ic_arvalid = 1'b1; bus.ic_araddr = 32'h8000_0000; bus.ic_arlen = 8'd1;
    bus.ls_arvalid = 1'b1; bus.ls_araddr = 32'h1000_0004; bus.ls_arsize = 3'b001;
    push_ar(1'b0, 32'h8000_0000, 8'd1, 3'b000);
    push_ar(1'b1, 32'h1000_0004, 8'd0, 3'b001);
    wait_ar(1'b1, 1'b0);
    beats(1'b0, 2, 1, 1, 2'b00);
    wait_ar(1'b0, 1'b1);
    beats(1'b1, 1, 0, 0, 2'b00);

    // Both held valid across four transactions: I, L, I, L.
    bus.ic_arvalid = 1'b1; bus.ic_araddr = 32'h8000_0100; bus.ic_arlen = 8'd1;
    bus.ls_arvalid = 1'b1; bus.ls_araddr = 32'h1000_0008; bus.ls_arsize = 3'b010;
    push_ar(1'b0, 32'h8000_0100, 8'd1, 3'b000);
    push_ar(1'b1, 32'h1000_0008, 8'd0, 3'b010);
    push_ar(1'b0, 32'h8000_0100, 8'd1, 3'b000);
    push_ar(1'b1, 32'h1000_0008, 8'd0, 3'b010);
    wait_ar(1'b0, 1'b0); beats(1'b0, 2, 1, 1, 2'b00);
    wait_ar(1'b0, 1'b0); beats(1'b1, 1, 0, 0, 2'b00);
    wait_ar(1'b0, 1'b0); beats(1'b0, 2, 1, 1, 2'b00);
    wait_ar(1'b1, 1'b1); beats(1'b1, 1, 0, 0, 2'b00);

    // Icache only, 4-beat burst.
    bus.ic_arvalid = 1'b1; bus.ic_araddr = 32'h3000_0000; bus.ic_arlen = 8'd3;
    push_ar(1'b0, 32'h3000_0000, 8'd3, 3'b000);
    wait_ar(1'b1, 1'b0);
    beats(1'b0, 4, 3, 3, 2'b00);

    // LSU load with SLVERR.
    bus.ls_arvalid = 1'b1; bus.ls_araddr = 32'h2000_0010; bus.ls_arsize = 3'b000;
    push_ar(1'b1, 32'h2000_0010, 8'd0, 3'b000);
    wait_ar(1'b0, 1'b1);
    beats(1'b1, 1, 0, 0, 2'b10);

    // Icache len 3 but memory ends the burst on the third beat.
    bus.ic_arvalid = 1'b1; bus.ic_araddr = 32'h3000_0040; bus.ic_arlen = 8'd3;
    push_ar(1'b0, 32'h3000_0040, 8'd3, 3'b000);
    wait_ar(1'b1, 1'b0);
    beats(1'b0, 3, 3, 2, 2'b00);

    // Reset during the first data beat, then a fresh LSU load.
    bus.ic_arvalid = 1'b1; bus.ic_araddr = 32'h4000_0000; bus.ic_arlen = 8'd3;
    push_ar(1'b0, 32'h4000_0000, 8'd3, 3'b000);
    wait_ar(1'b1, 1'b0);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hdead_beef; bus.m_rlast = 1'b0;
    reset = 1'b1;
    mdl_err_own = 1'b0;
    #1;
    `CHK("reset_mid_outs", all_outs(), 122'd0);
    step();
    `CHK("reset_held_outs", all_outs(), 122'd0);
    reset = 1'b0;
    bus.m_rvalid = 1'b0;
    step();
    bus.ls_arvalid = 1'b1; bus.ls_araddr = 32'h5000_0000; bus.ls_arsize = 3'b010;
    push_ar(1'b1, 32'h5000_0000, 8'd0, 3'b010);
    wait_ar(1'b0, 1'b1);
    beats(1'b1, 1, 0, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
